// File: rtl/hb_rd_capture_ctrl_pkg.sv
// Shared types and defaults for the RWDS read-capture controller.
// Controller states are one-hot so each state flag is a single flop.
package hb_rd_capture_ctrl_pkg;

    localparam int unsigned DEF_LEN_WIDTH = 8;
    localparam int unsigned DEF_TIMEOUT   = 64;
    localparam int unsigned DEF_SRST_HOLD = 4;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StArm   = 4'b0010,
        StRecv  = 4'b0100,
        StFlush = 4'b1000
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hb_timeout_cnt.sv
// Cycle counter with synchronous clear; flags the terminal cycle C_TIMEOUT-1 while enabled.
module hb_timeout_cnt
    import hb_rd_capture_ctrl_pkg::*;
#(
    parameter int unsigned C_TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned   CNT_W = cnt_width(C_TIMEOUT);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(C_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at terminal count; the controller leaves the waiting states there anyway.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TC_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = i_en && (r_cnt == TC_VAL);

endmodule

// File: rtl/hb_rd_capture_ctrl.sv
// Read-burst controller for the RWDS elastic buffer: releases the buffer for one command,
// forwards words up to the commanded length, times out on missing RWDS, then flushes.
module hb_rd_capture_ctrl
    import hb_rd_capture_ctrl_pkg::*;
#(
    parameter int unsigned C_LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int unsigned C_TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned C_SRST_HOLD = DEF_SRST_HOLD
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_cmd_valid,
    input  logic [C_LEN_WIDTH-1:0] i_cmd_len,
    output logic                   o_cmd_ready,
    output logic                   o_buf_srst,
    input  logic [15:0]            i_buf_dout,
    input  logic                   i_buf_dout_vld,
    output logic [15:0]            o_rd_data,
    output logic                   o_rd_valid,
    output logic                   o_rd_last,
    output logic                   o_done,
    output logic                   o_err_timeout,
    output logic [C_LEN_WIDTH:0]   o_rx_count
);

    localparam int unsigned        FLUSH_W    = cnt_width(C_SRST_HOLD);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(C_SRST_HOLD - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [C_LEN_WIDTH-1:0] r_len;
    logic [C_LEN_WIDTH:0]   r_words;
    logic [FLUSH_W-1:0]     r_flush_cnt;
    logic                   r_err;
    logic                   r_init;
    logic [15:0]            r_rd_data;
    logic                   r_rd_valid;
    logic                   r_rd_last;

    logic w_accept;
    logic w_word;
    logic w_last_word;
    logic w_flush_last;
    logic w_err_set;
    logic w_busy;
    logic w_tmo_tc;
    logic w_tmo_clr;

    assign w_busy    = (r_state == StArm) || (r_state == StRecv);
    assign w_tmo_clr = w_accept || w_word;

    hb_timeout_cnt #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_timeout_cnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (w_tmo_clr),
        .i_en   (w_busy),
        .o_tc   (w_tmo_tc)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_word       = 1'b0;
        w_err_set    = 1'b0;
        o_cmd_ready  = 1'b0;
        o_buf_srst   = 1'b1;
        o_done       = 1'b0;
        w_last_word  = (r_words == {1'b0, r_len});
        w_flush_last = (r_flush_cnt == FLUSH_LAST);
        unique case (r_state)
            StIdle: begin
                // r_init keeps cmd_ready low for the first cycle out of reset.
                o_cmd_ready = !r_init;
                if (i_cmd_valid && !r_init) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StArm;
                end
            end
            StArm, StRecv: begin
                o_buf_srst = 1'b0;
                // A word on the terminal-count cycle still counts as on time.
                if (i_buf_dout_vld) begin
                    w_word      = 1'b1;
                    w_state_nxt = w_last_word ? StFlush : StRecv;
                end else if (w_tmo_tc) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = StFlush;
                end
            end
            StFlush: begin
                if (w_flush_last) begin
                    o_done      = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= StIdle;
            r_init      <= 1'b1;
            r_len       <= '0;
            r_words     <= '0;
            r_flush_cnt <= '0;
            r_err       <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init     <= 1'b0;
            r_rd_valid <= w_word;
            r_rd_last  <= w_word && w_last_word;
            if (w_word) begin
                r_rd_data <= i_buf_dout;
            end
            if (w_accept) begin
                r_len   <= i_cmd_len;
                r_words <= '0;
                r_err   <= 1'b0;
            end else if (w_word) begin
                r_words <= r_words + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (r_state == StFlush) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_last     = r_rd_last;
    assign o_err_timeout = o_done && r_err;
    assign o_rx_count    = r_words;

endmodule
